// File: rtl/ika87ad_opfetch.sv
// Opcode fetch unit: fetches one opcode (optionally preceded by a page prefix
// byte), or injects the interrupt opcode, and holds it for the decoder until
// it is accepted. Every output is driven directly from a flip-flop.
module ika87ad_opfetch #(
    parameter logic [7:0] INT_OPCODE = 8'h73
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_START,
    input  logic       i_INT_PEND,
    input  logic       i_SKIP,
    input  logic       i_RDVALID,
    input  logic [7:0] i_RDDATA,
    input  logic       i_DEC_READY,
    output logic       o_FETCH_EN,
    output logic       o_PC_INC,
    output logic [7:0] o_OPCODE,
    output logic [2:0] o_OPCODE_PAGE,
    output logic       o_OP_VALID,
    output logic       o_SKIPPED,
    output logic       o_INT_ACK,
    output logic       o_BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [2:0] page_q, page_d;
    logic       skip_q, skip_d;
    logic       pc_inc_q, pc_inc_d;
    logic       int_ack_q, int_ack_d;
    logic       fetch_en_q, op_valid_q, busy_q;
    logic [2:0] pfx_page;

    // Map a prefix byte to its opcode page; zero means "not a prefix".
    always_comb begin
        pfx_page = 3'd0;
        case (i_RDDATA)
            8'h48:   pfx_page = 3'd1;
            8'h60:   pfx_page = 3'd2;
            8'h64:   pfx_page = 3'd3;
            8'h70:   pfx_page = 3'd4;
            8'h74:   pfx_page = 3'd5;
            default: pfx_page = 3'd0;
        endcase
    end

    // Next-state and next-output logic of the fetch sequencer.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        page_d    = page_q;
        skip_d    = skip_q;
        pc_inc_d  = 1'b0;
        int_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_START) begin
                    if (i_INT_PEND && !i_SKIP) begin
                        // Interrupt entry: no bus fetch, PC untouched.
                        state_d   = HOLD;
                        opcode_d  = INT_OPCODE;
                        page_d    = 3'd0;
                        skip_d    = 1'b0;
                        int_ack_d = 1'b1;
                    end else begin
                        // A skipped instruction still fetches normally, so the
                        // interrupt waits for the next boundary.
                        state_d = FETCH1;
                        skip_d  = i_SKIP;
                        page_d  = 3'd0;
                    end
                end
            end
            FETCH1: begin
                if (i_RDVALID) begin
                    pc_inc_d = 1'b1;
                    if (pfx_page != 3'd0) begin
                        page_d  = pfx_page;
                        state_d = FETCH2;
                    end else begin
                        opcode_d = i_RDDATA;
                        page_d   = 3'd0;
                        state_d  = HOLD;
                    end
                end
            end
            FETCH2: begin
                // Second byte is taken literally; prefixes do not nest.
                if (i_RDVALID) begin
                    pc_inc_d = 1'b1;
                    opcode_d = i_RDDATA;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (i_DEC_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; status flags are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q    <= IDLE;
            opcode_q   <= 8'h00;
            page_q     <= 3'd0;
            skip_q     <= 1'b0;
            pc_inc_q   <= 1'b0;
            int_ack_q  <= 1'b0;
            fetch_en_q <= 1'b0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            page_q     <= page_d;
            skip_q     <= skip_d;
            pc_inc_q   <= pc_inc_d;
            int_ack_q  <= int_ack_d;
            fetch_en_q <= (state_d == FETCH1) || (state_d == FETCH2);
            op_valid_q <= (state_d == HOLD);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign o_FETCH_EN    = fetch_en_q;
    assign o_PC_INC      = pc_inc_q;
    assign o_OPCODE      = opcode_q;
    assign o_OPCODE_PAGE = page_q;
    assign o_OP_VALID    = op_valid_q;
    assign o_SKIPPED     = skip_q;
    assign o_INT_ACK     = int_ack_q;
    assign o_BUSY        = busy_q;

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Self-checking bench for the opcode fetch unit: a driver pushes the expected
// delivery of each instruction into a scoreboard, a monitor pops and compares
// it when o_OP_VALID rises.
module tb_ika87ad_opfetch;

    logic       clk;
    logic       i_RST, i_START, i_INT_PEND, i_SKIP, i_RDVALID, i_DEC_READY;
    logic [7:0] i_RDDATA;
    logic       o_FETCH_EN, o_PC_INC, o_OP_VALID, o_SKIPPED, o_INT_ACK, o_BUSY;
    logic [7:0] o_OPCODE;
    logic [2:0] o_OPCODE_PAGE;

    typedef struct {
        logic [7:0] opcode;
        logic [2:0] page;
        logic       skipped;
        int         pc;
        int         fe;
        int         ack;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    ika87ad_opfetch #(.INT_OPCODE(8'h73)) dut (
        .i_EMUCLK     (clk),
        .i_RST        (i_RST),
        .i_START      (i_START),
        .i_INT_PEND   (i_INT_PEND),
        .i_SKIP       (i_SKIP),
        .i_RDVALID    (i_RDVALID),
        .i_RDDATA     (i_RDDATA),
        .i_DEC_READY  (i_DEC_READY),
        .o_FETCH_EN   (o_FETCH_EN),
        .o_PC_INC     (o_PC_INC),
        .o_OPCODE     (o_OPCODE),
        .o_OPCODE_PAGE(o_OPCODE_PAGE),
        .o_OP_VALID   (o_OP_VALID),
        .o_SKIPPED    (o_SKIPPED),
        .o_INT_ACK    (o_INT_ACK),
        .o_BUSY       (o_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] page_of(input logic [7:0] b);
        case (b)
            8'h48:   return 3'd1;
            8'h60:   return 3'd2;
            8'h64:   return 3'd3;
            8'h70:   return 3'd4;
            8'h74:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // Monitor: accumulate strobes over one instruction, compare on delivery.
    initial begin : monitor
        int   pc_cnt, fe_cnt, ack_cnt;
        logic prev_valid;
        exp_t e;
        pc_cnt = 0; fe_cnt = 0; ack_cnt = 0; prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!o_BUSY) begin
                pc_cnt = 0; fe_cnt = 0; ack_cnt = 0; prev_valid = 1'b0;
            end else begin
                pc_cnt  += int'(o_PC_INC);
                fe_cnt  += int'(o_FETCH_EN);
                ack_cnt += int'(o_INT_ACK);
                if (o_OP_VALID && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("opcode", int'(o_OPCODE), int'(e.opcode));
                        check("page", int'(o_OPCODE_PAGE), int'(e.page));
                        check("skipped", int'(o_SKIPPED), int'(e.skipped));
                        check("pc_inc_cnt", pc_cnt, e.pc);
                        check("fetch_cycles", fe_cnt, e.fe);
                        check("int_ack_cnt", ack_cnt, e.ack);
                        $display("delivered op=%02h page=%0d skip=%0d pc=%0d fe=%0d ack=%0d",
                                 o_OPCODE, o_OPCODE_PAGE, o_SKIPPED, pc_cnt, fe_cnt, ack_cnt);
                    end
                end
                prev_valid = o_OP_VALID;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fetch"}, int'(o_FETCH_EN), 0);
        check({tag, "_pcinc"}, int'(o_PC_INC), 0);
        check({tag, "_valid"}, int'(o_OP_VALID), 0);
        check({tag, "_ack"}, int'(o_INT_ACK), 0);
        check({tag, "_skip"}, int'(o_SKIPPED), 0);
        check({tag, "_busy"}, int'(o_BUSY), 0);
        check({tag, "_opcode"}, int'(o_OPCODE), 0);
        check({tag, "_page"}, int'(o_OPCODE_PAGE), 0);
    endtask

    // Drive one instruction boundary; keep_ip holds i_INT_PEND high during
    // the byte fetch, hold_w stalls the decoder while i_START is pulsed.
    task automatic run_instr(input logic ip, input logic sk, input logic keep_ip,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input int w, input int hold_w);
        exp_t e;
        logic taken;
        int   nb, t;
        taken = ip && !sk;
        nb = taken ? 0 : ((page_of(b0) != 3'd0) ? 2 : 1);
        e.opcode  = taken ? 8'h73 : ((nb == 2) ? b1 : b0);
        e.page    = taken ? 3'd0 : page_of(b0);
        e.skipped = taken ? 1'b0 : sk;
        e.pc      = nb;
        e.fe      = nb * (w + 1);
        e.ack     = taken ? 1 : 0;
        sb_q.push_back(e);

        @(negedge clk);
        i_START = 1'b1; i_INT_PEND = ip; i_SKIP = sk;
        @(negedge clk);
        i_START = 1'b0; i_INT_PEND = keep_ip; i_SKIP = 1'b0;
        for (int k = 0; k < nb; k++) begin
            repeat (w) @(negedge clk);
            i_RDVALID = 1'b1;
            i_RDDATA  = (k == 0) ? b0 : b1;
            @(negedge clk);
            i_RDVALID = 1'b0;
            i_RDDATA  = 8'h00;
        end
        i_INT_PEND = 1'b0;
        t = 0;
        while (!o_OP_VALID && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("valid_timeout", int'(t < 20), 1);
        for (int h = 0; h < hold_w; h++) begin
            i_START   = h[0];
            i_RDVALID = 1'b1;
            i_RDDATA  = 8'h55;
            @(negedge clk);
            check("hold_valid", int'(o_OP_VALID), 1);
            check("hold_opcode", int'(o_OPCODE), int'(e.opcode));
            check("hold_page", int'(o_OPCODE_PAGE), int'(e.page));
            check("hold_fetch", int'(o_FETCH_EN), 0);
            check("hold_pcinc", int'(o_PC_INC), 0);
        end
        i_START = 1'b0; i_RDVALID = 1'b0; i_RDDATA = 8'h00;
        i_DEC_READY = 1'b1;
        @(negedge clk);
        i_DEC_READY = 1'b0;
        check("release_valid", int'(o_OP_VALID), 0);
        check("release_busy", int'(o_BUSY), 0);
        check("release_fetch", int'(o_FETCH_EN), 0);
        $display("instr ip=%0d sk=%0d b0=%02h b1=%02h w=%0d hold=%0d", ip, sk, b0, b1, w, hold_w);
    endtask

    initial begin : driver
        logic [7:0] rb0, rb1;
        i_RST = 1'b1; i_START = 1'b0; i_INT_PEND = 1'b0; i_SKIP = 1'b0;
        i_RDVALID = 1'b0; i_RDDATA = 8'h00; i_DEC_READY = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        i_RST = 1'b0;
        @(negedge clk);

        run_instr(1'b0, 1'b0, 1'b0, 8'h1A, 8'h00, 2, 0);   // plain byte, 2 waits
        run_instr(1'b0, 1'b0, 1'b1, 8'h70, 8'h3F, 0, 0);   // page 4, interrupt held
        run_instr(1'b0, 1'b0, 1'b0, 8'h48, 8'h48, 1, 0);   // prefix not re-decoded
        run_instr(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 0, 0);   // interrupt entry
        run_instr(1'b1, 1'b1, 1'b0, 8'h60, 8'h11, 0, 0);   // skip beats interrupt
        run_instr(1'b0, 1'b1, 1'b0, 8'h74, 8'hAB, 3, 0);   // skipped page 5
        run_instr(1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 0, 5);   // decoder stall

        // Reset while waiting for the second byte of a prefixed opcode.
        @(negedge clk);
        i_START = 1'b1;
        @(negedge clk);
        i_START = 1'b0; i_RDVALID = 1'b1; i_RDDATA = 8'h64;
        @(negedge clk);
        i_RDVALID = 1'b0;
        check("mid_fetch2_en", int'(o_FETCH_EN), 1);
        check("mid_fetch2_page", int'(o_OPCODE_PAGE), 3);
        i_RST = 1'b1; i_RDVALID = 1'b1; i_RDDATA = 8'h99; i_DEC_READY = 1'b1;
        @(negedge clk);
        i_RST = 1'b0; i_RDVALID = 1'b0; i_RDDATA = 8'h00; i_DEC_READY = 1'b0;
        check_reset_outputs("midrst");
        run_instr(1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 0, 0);

        for (int r = 0; r < 4; r++) begin
            rb0 = 8'($urandom_range(0, 255));
            rb1 = 8'($urandom_range(0, 255));
            run_instr(1'b0, 1'($urandom_range(0, 1)), 1'b0, rb0, rb1,
                      int'($urandom_range(0, 2)), 0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
